// File: rtl/mnist_train_sequencer.sv
// Training-stream sequencer for the DNN: per-case cycle/mux/case selects,
// output-window compare, and running error/accuracy statistics.
module mnist_train_sequencer #(
  parameter int unsigned CPC            = 18,
  parameter int unsigned N_FEED         = CPC - 2,
  parameter int unsigned TRAINING_CASES = 5000,
  parameter int unsigned MAX_TRAIN      = 10000,
  parameter int unsigned WINDOW         = 100,
  localparam int unsigned CIW = (CPC > 1) ? $clog2(CPC) : 1,
  localparam int unsigned SNW = (N_FEED > 1) ? $clog2(N_FEED) : 1,
  localparam int unsigned TCW = (TRAINING_CASES > 1) ? $clog2(TRAINING_CASES) : 1,
  localparam int unsigned RW  = $clog2(WINDOW + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           a_out,
  input  logic           y_out,
  output logic [CIW-1:0] cycle_index,
  output logic [SNW-1:0] sel_network,
  output logic [TCW-1:0] sel_tc,
  output logic           cycle_clk,
  output logic           busy,
  output logic           done,
  output logic           epoch_done,
  output logic [31:0]    num_train,
  output logic [31:0]    total_error,
  output logic [15:0]    epoch,
  output logic [RW-1:0]  recent
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CIW-1:0]    ci_d;
  logic [CIW-1:0]    ci_off;
  logic              mismatch, boundary, err_final, wrap, last_case, case_err;
  logic [WINDOW-1:0] hist;

  assign mismatch = a_out ^ y_out;

  always_comb begin
    boundary  = (state_q == S_RUN) && (cycle_index == CIW'(CPC - 1));
    err_final = case_err | mismatch;
    wrap      = (sel_tc == TCW'(TRAINING_CASES - 1));
    last_case = ((num_train + 32'd1) == 32'(MAX_TRAIN));
    state_d   = state_q;
    ci_d      = cycle_index;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        ci_d = boundary ? '0 : cycle_index + CIW'(1);
        if (boundary && last_case) state_d = S_DONE;
      end
      default: ;
    endcase
    ci_off = ci_d - CIW'(2);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cycle_index <= '0;
      sel_network <= '0;
      sel_tc      <= '0;
      cycle_clk   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      epoch_done  <= 1'b0;
      num_train   <= '0;
      total_error <= '0;
      epoch       <= '0;
      recent      <= '0;
      case_err    <= 1'b0;
      hist        <= '0;
    end else begin
      state_q     <= state_d;
      cycle_index <= ci_d;
      // mux select tracks the index but stays at its reset value until a run begins
      if (state_q == S_RUN || state_d == S_RUN)
        sel_network <= (N_FEED > 1) ? SNW'(ci_off) : '0;
      cycle_clk   <= (state_d == S_RUN) && (ci_d == CIW'(CPC - 1));
      busy        <= (state_d == S_RUN);
      done        <= (state_d == S_DONE);
      epoch_done  <= boundary && wrap;

      if (state_q == S_RUN && cycle_index >= CIW'(2) && mismatch)
        case_err <= 1'b1;

      if (boundary) begin
        case_err  <= 1'b0;
        num_train <= num_train + 32'd1;
        if (err_final) total_error <= total_error + 32'd1;
        sel_tc <= wrap ? '0 : sel_tc + TCW'(1);
        if (wrap) epoch <= epoch + 16'd1;
        // oldest flag leaves from the top; zero-filled history keeps recent <= WINDOW
        hist   <= (hist << 1) | WINDOW'(!err_final);
        recent <= recent + RW'(!err_final) - RW'(hist[WINDOW-1]);
      end
    end
  end

endmodule

// File: tb/tb_mnist_train_sequencer.sv
// Directed bench for mnist_train_sequencer with CPC=6, N_FEED=4, 3 cases/epoch,
// 7 cases total, 4-deep recent window.
module tb_mnist_train_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, a_out, y_out;
  logic [2:0]  cycle_index;
  logic [1:0]  sel_network;
  logic [1:0]  sel_tc;
  logic        cycle_clk, busy, done, epoch_done;
  logic [31:0] num_train, total_error;
  logic [15:0] epoch;
  logic [2:0]  recent;
  logic [93:0] outs;

  int checks = 0;
  int errors = 0;

  mnist_train_sequencer #(
    .CPC(6), .N_FEED(4), .TRAINING_CASES(3), .MAX_TRAIN(7), .WINDOW(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .a_out(a_out), .y_out(y_out),
    .cycle_index(cycle_index), .sel_network(sel_network), .sel_tc(sel_tc),
    .cycle_clk(cycle_clk), .busy(busy), .done(done), .epoch_done(epoch_done),
    .num_train(num_train), .total_error(total_error), .epoch(epoch),
    .recent(recent)
  );

  always #5 clk = ~clk;

  assign outs = {cycle_index, sel_network, sel_tc, cycle_clk, busy, done,
                 epoch_done, num_train, total_error, epoch, recent};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One case from cycle_index 0; mm bit i forces a mismatch at index i.
  task automatic run_case(input logic [5:0] mm, input bit chk_idx);
    for (int i = 0; i < 6; i++) begin
      if (chk_idx) begin
        chk("cycle_index", cycle_index, i);
        chk("sel_network", sel_network, (i + 2) % 4);
        chk("cycle_clk", cycle_clk, i == 5);
      end
      if (i > 0) chk("epoch_done_width", epoch_done, 0);
      y_out = 1'($urandom_range(0, 1));
      a_out = y_out ^ mm[i];
      step();
    end
    a_out = 1'b0;
    y_out = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] mm_b [6] = '{6'b100000, 6'b000011, 6'b000000, 6'b000000, 6'b000000, 6'b001100};
    int         te_b [6] = '{1, 1, 1, 1, 1, 2};
    int         rc_b [6] = '{0, 1, 2, 3, 4, 3};

    reset = 1'b0; start = 1'b0; a_out = 1'b0; y_out = 1'b0;
    repeat (3) step();
    chk("reset_outputs", outs, 0);
    start = 1'b1;
    step();
    chk("start_in_reset", outs, 0);

    // clean run to DONE
    reset = 1'b1;
    step();
    chk("busy_after_start", busy, 1);
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      run_case(6'd0, c == 1);
      chk("num_train", num_train, c);
      chk("sel_tc", sel_tc, c % 3);
      chk("epoch", epoch, c / 3);
      chk("epoch_done", epoch_done, (c == 3 || c == 6));
      chk("total_error_clean", total_error, 0);
    end
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("cycle_index_at_done", cycle_index, 0);
    chk("recent_clean", recent, 4);

    // DONE must ignore start and mismatches
    for (int k = 0; k < 8; k++) begin
      start = ~start;
      y_out = 1'b0;
      a_out = 1'($urandom_range(0, 1));
      step();
      chk("done_hold",
          {cycle_index, sel_tc, cycle_clk, busy, done, epoch_done, num_train, total_error, epoch, recent},
          {3'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7, 32'd0, 16'd2, 3'd4});
    end

    // error windowing and recent window
    start = 1'b0; a_out = 1'b0;
    reset = 1'b0;
    step();
    chk("reset_after_done", outs, 0);
    reset = 1'b1; start = 1'b1;
    step();
    chk("busy_run_b", busy, 1);
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      run_case(mm_b[c], 1'b0);
      chk("total_error_win", total_error, te_b[c]);
      chk("recent", recent, rc_b[c]);
      chk("num_train_b", num_train, c + 1);
    end

    // mid-case reset in case 2
    reset = 1'b0; start = 1'b1;
    step();
    chk("reset_run_b", outs, 0);
    step();
    chk("start_ignored_in_reset", outs, 0);
    reset = 1'b1;
    step();
    chk("busy_run_c", busy, 1);
    start = 1'b0;
    run_case(6'b001000, 1'b0);
    chk("total_error_c1", total_error, 1);
    for (int i = 0; i < 3; i++) begin
      y_out = 1'b0;
      a_out = (i == 2);
      step();
    end
    a_out = 1'b0;
    chk("cycle_index_pre_reset", cycle_index, 3);
    reset = 1'b0; start = 1'b1;
    step();
    chk("mid_case_reset", outs, 0);
    step();
    chk("mid_case_start_ignored", outs, 0);
    reset = 1'b1; start = 1'b0;
    step();
    chk("idle_after_reset", outs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
